// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared FSM states, activation-mux encodings and saturating add
package perceptron_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_COMPUTE, S_UPDATE, S_DONE} state_t;
  localparam logic [1:0] ACT_POS = 2'b00;
  localparam logic [1:0] ACT_ZERO = 2'b01;
  localparam logic [1:0] ACT_NEG = 2'b10;
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] d, input int w);
    logic signed [31:0] s, hi, lo;
    s = a + d;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/perceptron_mac.sv
// perceptron_mac: full-precision net input and three-level threshold activation
module perceptron_mac import perceptron_pkg::*; #(
  parameter int N = 8,
  parameter int WW = 12,
  parameter int THETA = 0
) (
  input  logic signed [WW-1:0]     w1,
  input  logic signed [WW-1:0]     w2,
  input  logic signed [WW-1:0]     b,
  input  logic signed [N-1:0]      x1,
  input  logic signed [N-1:0]      x2,
  input  logic signed [WW+N+1:0]   yin_q,
  output logic signed [WW+N+1:0]   yin,
  output logic signed [1:0]        y,
  output logic [1:0]               act_sel
);
  localparam int Y = WW + N + 2;
  localparam logic signed [Y-1:0] TH = Y'(THETA);
  logic signed [Y-1:0] p1, p2;
  always_comb begin
    p1 = Y'(w1) * Y'(x1);
    p2 = Y'(w2) * Y'(x2);
    yin = Y'(b) + p1 + p2;
    y = yin_q > TH ? 2'sd1 : yin_q < -TH ? -2'sd1 : 2'sd0;
    act_sel = yin_q > TH ? ACT_POS : yin_q < -TH ? ACT_NEG : ACT_ZERO;
  end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: streaming perceptron-rule trainer; act_sel drives the downstream activation mux
module perceptron_trainer import perceptron_pkg::*; #(
  parameter int N = 8,
  parameter int WW = 12,
  parameter int THETA = 0,
  parameter int MAX_EPOCHS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  in_x1,
  input  logic signed [N-1:0]  in_x2,
  input  logic signed [1:0]    in_t,
  input  logic                 in_last,
  output logic signed [WW-1:0] w1,
  output logic signed [WW-1:0] w2,
  output logic signed [WW-1:0] b,
  output logic signed [1:0]    y_out,
  output logic [1:0]           act_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [7:0]           epoch_cnt,
  output logic [7:0]           err_cnt
);
  localparam int Y = WW + N + 2;
  localparam logic [7:0] MAX_E = 8'(MAX_EPOCHS);
  state_t state_q, state_d;
  logic signed [WW-1:0] w1_q, w1_d, w2_q, w2_d, b_q, b_d;
  logic signed [N-1:0] x1_q, x1_d, x2_q, x2_d;
  logic t_neg_q, t_neg_d, last_q, last_d, conv_q, conv_d, miss;
  logic signed [Y-1:0] yin_q, yin_d, yin_c;
  logic signed [1:0] y_q, y_d, y_c, t_c;
  logic [1:0] act_q, act_d, act_c;
  logic [7:0] epoch_q, epoch_d, err_q, err_d, err_inc, epoch_inc;
  perceptron_mac #(.N(N), .WW(WW), .THETA(THETA)) u_mac (
    .w1(w1_q), .w2(w2_q), .b(b_q), .x1(x1_q), .x2(x2_q),
    .yin_q(yin_q), .yin(yin_c), .y(y_c), .act_sel(act_c)
  );
  always_comb begin
    state_d = state_q;
    w1_d = w1_q;
    w2_d = w2_q;
    b_d = b_q;
    x1_d = x1_q;
    x2_d = x2_q;
    t_neg_d = t_neg_q;
    last_d = last_q;
    conv_d = conv_q;
    yin_d = yin_q;
    y_d = y_q;
    act_d = act_q;
    epoch_d = epoch_q;
    err_d = err_q;
    t_c = t_neg_q ? -2'sd1 : 2'sd1;
    miss = y_c != t_c;
    err_inc = err_q + 8'(miss && err_q != 8'hff);
    epoch_inc = epoch_q + 8'd1;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        w1_d = '0;
        w2_d = '0;
        b_d = '0;
        epoch_d = '0;
        err_d = '0;
        conv_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: if (in_valid) begin
        x1_d = in_x1;
        x2_d = in_x2;
        t_neg_d = in_t < 2'sd0;
        last_d = in_last;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        yin_d = yin_c;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        y_d = y_c;
        act_d = act_c;
        if (miss) begin
          w1_d = WW'(sat_add(32'(w1_q), t_neg_q ? -32'(x1_q) : 32'(x1_q), WW));
          w2_d = WW'(sat_add(32'(w2_q), t_neg_q ? -32'(x2_q) : 32'(x2_q), WW));
          b_d = WW'(sat_add(32'(b_q), t_neg_q ? -32'sd1 : 32'sd1, WW));
        end
        err_d = err_inc;
        state_d = S_WAIT;
        // epoch decision uses the error count including this sample
        if (last_q) begin
          epoch_d = epoch_inc;
          if (err_inc == 8'd0) begin
            state_d = S_DONE;
            conv_d = 1'b1;
          end else if (epoch_inc >= MAX_E) state_d = S_DONE;
          else err_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w1_q <= '0;
      w2_q <= '0;
      b_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
      t_neg_q <= 1'b0;
      last_q <= 1'b0;
      conv_q <= 1'b0;
      yin_q <= '0;
      y_q <= '0;
      act_q <= ACT_ZERO;
      epoch_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
      b_q <= b_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      t_neg_q <= t_neg_d;
      last_q <= last_d;
      conv_q <= conv_d;
      yin_q <= yin_d;
      y_q <= y_d;
      act_q <= act_d;
      epoch_q <= epoch_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == S_WAIT;
  assign busy = !(state_q == S_IDLE || state_q == S_DONE);
  assign done = state_q == S_DONE;
  assign converged = conv_q;
  assign w1 = w1_q;
  assign w2 = w2_q;
  assign b = b_q;
  assign y_out = y_q;
  assign act_sel = act_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed scenarios for AND, XOR, saturation, back-pressure and resets
module tb_perceptron_trainer;
  import perceptron_pkg::*;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_last, in_ready, busy, done, converged;
  logic signed [7:0] in_x1, in_x2;
  logic signed [1:0] in_t, y_out;
  logic signed [11:0] w1, w2, b;
  logic [1:0] act_sel;
  logic [7:0] epoch_cnt, err_cnt;
  logic s_start, s_valid, s_last, s_ready, s_busy, s_done, s_conv;
  logic signed [3:0] s_x1, s_x2, s_w1, s_w2, s_b;
  logic signed [1:0] s_t, s_y;
  logic [1:0] s_act;
  logic [7:0] s_epoch, s_err;
  int errors = 0;
  int checks = 0;
  int ax1[4] = '{1, 1, -1, -1};
  int ax2[4] = '{1, -1, 1, -1};
  int at[4] = '{1, -1, -1, -1};
  int xt[4] = '{-1, 1, 1, -1};

  always #5 clk = ~clk;

  perceptron_trainer #(.N(8), .WW(12), .THETA(0), .MAX_EPOCHS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_t(in_t), .in_last(in_last),
    .w1(w1), .w2(w2), .b(b), .y_out(y_out), .act_sel(act_sel), .busy(busy),
    .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );

  perceptron_trainer #(.N(4), .WW(4), .THETA(100), .MAX_EPOCHS(16)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_x1(s_x1), .in_x2(s_x2), .in_t(s_t), .in_last(s_last),
    .w1(s_w1), .w2(s_w2), .b(s_b), .y_out(s_y), .act_sel(s_act), .busy(s_busy),
    .done(s_done), .converged(s_conv), .epoch_cnt(s_epoch), .err_cnt(s_err)
  );

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int x1, input int x2, input int t, input logic last);
    int n = 0;
    @(negedge clk);
    in_x1 = 8'(x1);
    in_x2 = 8'(x2);
    in_t = 2'(t);
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && !done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(in_ready || done)) begin
      errors++;
      $display("FAIL settle_timeout: in_ready=%0b done=%0b required one high", in_ready, done);
    end
  endtask

  task automatic run_set(input bit use_xor, input int gap);
    for (int e = 0; e < 8 && !done; e++)
      for (int i = 0; i < 4; i++) begin
        send(ax1[i], ax2[i], use_xor ? xt[i] : at[i], i == 3);
        settle();
        for (int g = 0; g < gap && !done; g++) begin
          @(negedge clk);
          checks++;
          if (!(in_ready && busy)) begin
            errors++;
            $display("FAIL bp_wait: in_ready=%0b busy=%0b required 1 1", in_ready, busy);
          end
        end
      end
  endtask

  task automatic check_and_result(input string tag);
    checks++;
    if ({w1, w2, b} !== {12'sd1, 12'sd1, -12'sd1}) begin
      errors++;
      $display("FAIL %s_weights: w1=%0d w2=%0d b=%0d required 1 1 -1", tag, w1, w2, b);
    end
    checks++;
    if ({done, converged, busy, epoch_cnt, err_cnt} !== {3'b110, 8'd2, 8'd0}) begin
      errors++;
      $display("FAIL %s_status: done=%0b conv=%0b busy=%0b epoch=%0d err=%0d required 1 1 0 2 0",
               tag, done, converged, busy, epoch_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({w1, w2, b, epoch_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_regs: w1=%0d w2=%0d b=%0d epoch=%0d err=%0d required all 0", w1, w2, b, epoch_cnt, err_cnt);
    end
    checks++;
    if ({act_sel, y_out, in_ready, busy, done, converged} !== {ACT_ZERO, 2'b00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_ctrl: act=%b y=%0d rdy=%0b busy=%0b done=%0b conv=%0b required 01 0 0 0 0 0",
               act_sel, y_out, in_ready, busy, done, converged);
    end
  endtask

  task automatic test_and();
    pulse_start();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL and_start: busy=%0b in_ready=%0b required 1 1", busy, in_ready);
    end
    send(1, 1, 1, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timing_compute_ready: in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || w1 !== 12'sd0) begin
      errors++;
      $display("FAIL timing_update_ready: in_ready=%0b w1=%0d required 0 0", in_ready, w1);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, w1, w2, b, err_cnt, y_out, act_sel} !== {1'b1, 12'sd1, 12'sd1, 12'sd1, 8'd1, 2'b00, ACT_ZERO}) begin
      errors++;
      $display("FAIL timing_first_update: rdy=%0b w1=%0d w2=%0d b=%0d err=%0d y=%0d act=%b required 1 1 1 1 1 0 01",
               in_ready, w1, w2, b, err_cnt, y_out, act_sel);
    end
    for (int i = 1; i < 4; i++) begin
      send(ax1[i], ax2[i], at[i], i == 3);
      settle();
    end
    checks++;
    if ({w1, w2, b, epoch_cnt, err_cnt, y_out, act_sel} !== {12'sd1, 12'sd1, -12'sd1, 8'd1, 8'd0, -2'sd1, ACT_NEG}) begin
      errors++;
      $display("FAIL and_epoch1: w1=%0d w2=%0d b=%0d epoch=%0d err=%0d y=%0d act=%b required 1 1 -1 1 0 -1 10",
               w1, w2, b, epoch_cnt, err_cnt, y_out, act_sel);
    end
    run_set(1'b0, 0);
    check_and_result("and");
  endtask

  task automatic test_back_pressure();
    pulse_start();
    checks++;
    if ({w1, w2, b, epoch_cnt, converged, done} !== '0) begin
      errors++;
      $display("FAIL restart_clear: w1=%0d w2=%0d b=%0d epoch=%0d conv=%0b done=%0b required all 0",
               w1, w2, b, epoch_cnt, converged, done);
    end
    run_set(1'b0, 5);
    check_and_result("bp");
  endtask

  task automatic test_start_busy();
    pulse_start();
    send(1, 1, 1, 1'b0);
    settle();
    pulse_start();
    checks++;
    if ({w1, w2, b, err_cnt, busy, in_ready} !== {12'sd1, 12'sd1, 12'sd1, 8'd1, 2'b11}) begin
      errors++;
      $display("FAIL start_busy: w1=%0d w2=%0d b=%0d err=%0d busy=%0b rdy=%0b required 1 1 1 1 1 1",
               w1, w2, b, err_cnt, busy, in_ready);
    end
    run_set(1'b0, 0);
    check_and_result("busy");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(1, 1, 1, 1'b0);
    settle();
    send(1, -1, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({w1, w2, b, epoch_cnt, err_cnt, y_out, act_sel, in_ready, busy, done, converged} !==
        {12'sd0, 12'sd0, 12'sd0, 8'd0, 8'd0, 2'b00, ACT_ZERO, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid: w1=%0d w2=%0d b=%0d epoch=%0d err=%0d y=%0d act=%b rdy=%0b busy=%0b done=%0b conv=%0b required 0s act 01",
               w1, w2, b, epoch_cnt, err_cnt, y_out, act_sel, in_ready, busy, done, converged);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: busy=%0b required 0", busy);
    end
    pulse_start();
    run_set(1'b0, 0);
    check_and_result("rst");
  endtask

  task automatic test_xor();
    pulse_start();
    run_set(1'b1, 0);
    checks++;
    if ({done, converged, epoch_cnt} !== {2'b10, 8'd4}) begin
      errors++;
      $display("FAIL xor_limit: done=%0b conv=%0b epoch=%0d required 1 0 4", done, converged, epoch_cnt);
    end
    checks++;
    if (err_cnt == 8'd0) begin
      errors++;
      $display("FAIL xor_errs: err=%0d required nonzero", err_cnt);
    end
  endtask

  task automatic test_saturation();
    int n;
    s_x1 = 4'sd7;
    s_x2 = 4'sd0;
    s_t = 2'sd1;
    s_last = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      n = 0;
      while (s_epoch != 8'(e) && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if ({s_epoch, s_w1, s_w2, s_b} !== {8'(e), 4'sd7, 4'sd0, 4'(e)}) begin
        errors++;
        $display("FAIL sat_epoch%0d: epoch=%0d w1=%0d w2=%0d b=%0d required %0d 7 0 %0d", e, s_epoch, s_w1, s_w2, s_b, e, e);
      end
    end
    n = 0;
    while (!s_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    checks++;
    if ({s_done, s_conv, s_epoch, s_err, s_w1, s_b} !== {2'b10, 8'd16, 8'd1, 4'sd7, 4'sd7}) begin
      errors++;
      $display("FAIL sat_final: done=%0b conv=%0b epoch=%0d err=%0d w1=%0d b=%0d required 1 0 16 1 7 7",
               s_done, s_conv, s_epoch, s_err, s_w1, s_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_x1 = '0;
    in_x2 = '0;
    in_t = 2'sd1;
    s_start = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_x1 = '0;
    s_x2 = '0;
    s_t = 2'sd1;
    test_reset();
    test_and();
    test_back_pressure();
    test_start_busy();
    test_reset_mid();
    test_xor();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
